pipeline_fetch_stage: RTL and testbench



---
 rtl/pipeline_pkg.sv | 18 +
 rtl/pipeline_fetch_stage_if.sv | 23 ++
 rtl/fetch_pc_sel.sv | 39 +++
 rtl/pipeline_fetch_stage.sv | 153 +++++++++++++++
 tb/tb_pipeline_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and fetch FSM encoding for the pipeline
package pipeline_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;
  localparam logic [31:0] NOP_INSTR_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipeline_fetch_stage_if.sv
// rtl/pipeline_fetch_stage_if.sv - instruction memory request/response bus
interface pipeline_fetch_stage_if;

  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/fetch_pc_sel.sv
// rtl/fetch_pc_sel.sv - fetch address priority mux (interrupt > eret > redirect > sequential)
module fetch_pc_sel
  import pipeline_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        interrupt,
  input  logic        eret,
  input  logic        redirect,
  input  logic        issue,
  input  logic [31:0] epc,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] pc_f,
  output logic        redir,
  output logic [31:0] fetch_addr,
  output logic [31:0] next_pc
);

  logic [31:0] sel_pc;

  always_comb begin
    redir  = 1'b1;
    sel_pc = pc_f;
    if (interrupt) begin
      sel_pc = EXC_VECTOR;
    end else if (eret) begin
      sel_pc = epc;
    end else if (redirect) begin
      sel_pc = redirect_pc;
    end else begin
      redir = 1'b0;
    end
  end

  // Misaligned targets are silently truncated to the containing word.
  assign fetch_addr = word_align(sel_pc);
  assign next_pc    = issue ? fetch_addr + 32'd4 : fetch_addr;

endmodule

// File: rtl/pipeline_fetch_stage.sv
// rtl/pipeline_fetch_stage.sv - instruction fetch with one outstanding request, skid buffer and IF/ID register
module pipeline_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  pipeline_fetch_stage_if.master        imem,
  input  logic                          i_stall,
  input  logic                          i_redirect,
  input  logic [31:0]                   i_redirect_pc,
  input  logic                          i_interrupt,
  input  logic                          i_eret,
  input  logic [31:0]                   i_epc,
  output logic [31:0]                   o_instruction,
  output logic [31:0]                   o_pc,
  output logic [31:0]                   o_pc_plus4,
  output logic                          o_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_f_q, pc_f_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         stale_q, stale_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;

  logic         issue;
  logic         redir;
  logic [31:0]  fetch_addr;
  logic [31:0]  next_pc;

  // A plain redirect waits out a stall; interrupt and eret do not.
  fetch_pc_sel #(.EXC_VECTOR(EXC_VECTOR)) u_pc_sel (
    .interrupt   (i_interrupt),
    .eret        (i_eret),
    .redirect    (i_redirect & ~i_stall),
    .issue       (issue),
    .epc         (i_epc),
    .redirect_pc (i_redirect_pc),
    .pc_f        (pc_f_q),
    .redir       (redir),
    .fetch_addr  (fetch_addr),
    .next_pc     (next_pc)
  );

  always_comb begin
    state_d      = state_q;
    stale_d      = stale_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    issue        = 1'b0;
    if (redir) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      if (state_q == S_WAIT && !imem.imem_valid) begin
        stale_d = 1'b1;
      end else begin
        stale_d = 1'b0;
        issue   = 1'b1;
      end
    end else if (i_stall) begin
      case (state_q)
        S_IDLE: issue = 1'b1;
        S_WAIT: begin
          if (imem.imem_valid) begin
            if (stale_q) begin
              stale_d = 1'b0;
              issue   = 1'b1;
            end else begin
              skid_instr_d = imem.imem_rdata;
              skid_pc_d    = req_pc_q;
              state_d      = S_FULL;
            end
          end
        end
        S_FULL: ;
        default: state_d = S_IDLE;
      endcase
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      case (state_q)
        S_IDLE: issue = 1'b1;
        S_WAIT: begin
          if (imem.imem_valid) begin
            if (!stale_q) begin
              instr_d = imem.imem_rdata;
              pc_d    = req_pc_q;
              valid_d = 1'b1;
            end
            stale_d = 1'b0;
            issue   = 1'b1;
          end
        end
        S_FULL: begin
          instr_d = skid_instr_q;
          pc_d    = skid_pc_q;
          valid_d = 1'b1;
          issue   = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (issue) begin
      state_d = S_WAIT;
    end
  end

  assign pc_f_d   = next_pc;
  assign req_pc_d = issue ? fetch_addr : req_pc_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      pc_f_q       <= RESET_PC;
      req_pc_q     <= RESET_PC;
      stale_q      <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      req_pc_q     <= req_pc_d;
      stale_q      <= stale_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

  assign imem.imem_req  = issue & ~i_rst;
  assign imem.imem_addr = i_rst ? RESET_PC : fetch_addr;
  assign o_instruction  = instr_q;
  assign o_pc           = pc_q;
  assign o_pc_plus4     = pc_q + 32'd4;
  assign o_valid        = valid_q;

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// tb/tb_pipeline_fetch_stage.sv - self-checking bench for pipeline_fetch_stage
module tb_pipeline_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC = 32'h0000_0180;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_stall = 1'b0, i_redirect = 1'b0, i_interrupt = 1'b0, i_eret = 1'b0;
  logic [31:0] i_redirect_pc = '0, i_epc = '0;
  logic [31:0] o_instruction, o_pc, o_pc_plus4;
  logic        o_valid;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_fetch_stage_if imem();

  pipeline_fetch_stage #(
    .RESET_PC   (RST_PC),
    .EXC_VECTOR (EXC_PC),
    .NOP_INSTR  (NOP)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .imem          (imem.master),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_interrupt   (i_interrupt),
    .i_eret        (i_eret),
    .i_epc         (i_epc),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .o_valid       (o_valid)
  );

  always #5 i_clk = ~i_clk;

  // Reference: program order of valid words, memory contents, one-outstanding memory
  logic [31:0] exp_pc;
  logic        hold_exp, bubble_exp;
  logic [31:0] prev_instr, prev_pc;
  logic        prev_valid;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat_lo, lat_hi;
  int          n_valid;
  logic        late_valid;
  logic [31:0] req_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc     = RST_PC;
    hold_exp   = 1'b0;
    bubble_exp = 1'b0;
    pend       = 1'b0;
    pend_cnt   = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, o_instruction, NOP);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_pc"}, o_pc, RST_PC);
    check({tag, "_pc4"}, o_pc_plus4, RST_PC + 32'd4);
    check({tag, "_req"}, 32'(imem.imem_req), 32'd0);
    check({tag, "_addr"}, imem.imem_addr, RST_PC);
  endtask

  // Called at posedge+1; checks outputs of the last edge, applies one cycle of stimulus.
  task automatic step(input logic st, input logic rd, input logic it, input logic er,
                      input logic [31:0] rpc, input logic [31:0] ep);
    logic [31:0] target;
    if (hold_exp) begin
      check("hold_instr", o_instruction, prev_instr);
      check("hold_pc", o_pc, prev_pc);
      check("hold_valid", 32'(o_valid), 32'(prev_valid));
    end else if (bubble_exp || !o_valid) begin
      check("bubble_valid", 32'(o_valid), 32'd0);
      check("bubble_instr", o_instruction, NOP);
    end else begin
      check("seq_pc", o_pc, exp_pc);
      check("instr", o_instruction, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_valid++;
    end
    check("pc_plus4", o_pc_plus4, o_pc + 32'd4);

    if (late_valid) begin
      imem.imem_valid = 1'b1;
      imem.imem_rdata = $urandom;
      late_valid      = 1'b0;
    end else if (pend && pend_cnt == 0) begin
      imem.imem_valid = 1'b1;
      imem.imem_rdata = mem_word(pend_addr);
      pend            = 1'b0;
    end else begin
      imem.imem_valid = 1'b0;
      imem.imem_rdata = $urandom;
      if (pend) pend_cnt--;
    end
    i_stall = st; i_redirect = rd; i_interrupt = it; i_eret = er;
    i_redirect_pc = rpc; i_epc = ep;
    #2;
    if (imem.imem_req) begin
      check("one_outstanding", 32'(pend), 32'd0);
      check("addr_align", 32'(imem.imem_addr[1:0]), 32'd0);
      req_log.push_back(imem.imem_addr);
      pend      = 1'b1;
      pend_addr = imem.imem_addr;
      pend_cnt  = $urandom_range(lat_hi, lat_lo);
    end
    target = it ? EXC_PC : er ? ep : rpc;
    if (it || er || (rd && !st)) begin
      bubble_exp = 1'b1;
      hold_exp   = 1'b0;
      exp_pc     = target & ~32'h3;
    end else begin
      bubble_exp = 1'b0;
      hold_exp   = st;
    end
    prev_instr = o_instruction;
    prev_pc    = o_pc;
    prev_valid = o_valid;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic run_to_valid(input string tag);
    int n = 0;
    while (!o_valid && n < 40) begin idle(); n++; end
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
  endtask

  task automatic run_to_pc(input string tag, input logic [31:0] pc);
    int n = 0;
    while (!(o_valid && o_pc == pc) && n < 200) begin idle(); n++; end
    check({tag, "_reach"}, o_pc, pc);
  endtask

  task automatic wait_pend(input string tag, input logic [31:0] a);
    int n = 0;
    while (!(pend && pend_addr == a) && n < 60) begin idle(); n++; end
    check({tag, "_pending"}, 32'(pend && pend_addr == a), 32'd1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_stall = 1'b0; i_redirect = 1'b0; i_interrupt = 1'b0; i_eret = 1'b0;
    imem.imem_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outputs("reset");
    i_rst = 1'b0;
  endtask

  initial begin
    int base;
    n_valid = 0; late_valid = 1'b0; lat_lo = 0; lat_hi = 0;
    imem.imem_valid = 1'b0; imem.imem_rdata = '0;

    // 1: zero-wait sequential fetch
    do_reset();
    base = req_log.size();
    for (int i = 0; i < 5; i++) begin
      check("t1_valid", 32'(o_valid), (i >= 2) ? 32'd1 : 32'd0);
      idle();
    end
    check("t1_req0", req_log[base], 32'h0);
    check("t1_req1", req_log[base + 1], 32'h4);
    check("t1_req2", req_log[base + 2], 32'h8);

    // 2: two-cycle stall at 0x10, skid word 0x14 follows
    run_to_pc("t2", 32'h10);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();
    check("t2_skid_pc", o_pc, 32'h14);
    check("t2_skid_valid", 32'(o_valid), 32'd1);

    // 3: redirect with 0x20 in ID
    run_to_pc("t3", 32'h20);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'd0);
    check("t3_bubble", 32'(o_valid), 32'd0);
    run_to_valid("t3");
    check("t3_target", o_pc, 32'h100);

    // 4: interrupt while 0x40 outstanding on 3-wait memory
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
    wait_pend("t4", 32'h40);
    base = req_log.size();
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    run_to_valid("t4");
    check("t4_first_pc", o_pc, EXC_PC);
    if (req_log.size() > base) check("t4_req", req_log[base], EXC_PC);
    else check("t4_req_seen", req_log.size(), base + 1);

    // 5: eret overrides stall
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'h2C);
    run_to_valid("t5");
    check("t5_epc", o_pc, 32'h2C);

    // Wrap of o_pc_plus4 and misaligned target
    lat_lo = 0; lat_hi = 1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF6, 32'd0);
    run_to_valid("wrap");
    check("wrap_first", o_pc, 32'hFFFF_FFF4);
    run_to_pc("wrap", 32'hFFFF_FFFC);
    check("wrap_pc4", o_pc_plus4, 32'h0);
    run_to_pc("wrap0", 32'h0);

    // 6: asynchronous reset mid-request at 0x8
    lat_lo = 2; lat_hi = 2;
    do_reset();
    wait_pend("t6", 32'h8);
    i_rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    imem.imem_valid = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    late_valid = 1'b1;
    base = req_log.size();
    run_to_valid("t6");
    check("t6_pc", o_pc, RST_PC);
    check("t6_instr", o_instruction, mem_word(RST_PC));
    if (req_log.size() > base) check("t6_req", req_log[base], RST_PC);
    else check("t6_req_seen", req_log.size(), base + 1);

    // Randomized traffic
    lat_lo = 0; lat_hi = 3;
    n_valid = 0;
    for (int c = 0; c < 1500; c++) begin
      logic        st, rd, it, er;
      logic [31:0] rpc, ep;
      st  = ($urandom_range(99, 0) < 20);
      rd  = ($urandom_range(99, 0) < 8);
      it  = ($urandom_range(99, 0) < 2);
      er  = ($urandom_range(99, 0) < 3);
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      ep  = $urandom;
      step(st, rd, it, er, rpc, ep);
    end
    check("liveness", 32'(n_valid > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
